// File: rtl/counter_seq_pkg.sv
// Shared types and default sizing for the command-driven counter sequencer.
package counter_seq_pkg;

    localparam int DEFAULT_WIDTH         = 16;
    localparam int DEFAULT_PRESCALE_BITS = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_STOP = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command channel into the sequencer: valid/ready handshake plus command payload.
interface counter_sequencer_if
    import counter_seq_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int PRESCALE_BITS = DEFAULT_PRESCALE_BITS
) ();

    logic                     cmd_valid;
    logic                     cmd_ready;
    op_t                      cmd_op;
    logic [WIDTH-1:0]         cmd_value;
    logic [PRESCALE_BITS-1:0] prescale;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_value,
        output prescale,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_value,
        input  prescale,
        output cmd_ready
    );

endinterface

// File: rtl/counter_sequencer_tick_divider.sv
// Prescale divider: counts enabled cycles and strobes when the count reaches the
// divisor latched at load time, then wraps to zero.
module tick_divider #(
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clock,
    input  logic                     reset_,
    input  logic                     load,
    input  logic                     enable,
    input  logic [PRESCALE_BITS-1:0] divisor,
    output logic                     strobe
);

    logic [PRESCALE_BITS-1:0] count_q, count_d;
    logic [PRESCALE_BITS-1:0] divisor_q, divisor_d;

    always_comb begin
        count_d   = count_q;
        divisor_d = divisor_q;
        strobe    = enable && (count_q == divisor_q);
        if (load) begin
            count_d   = '0;
            divisor_d = divisor;
        end else if (enable) begin
            count_d = strobe ? '0 : count_q + PRESCALE_BITS'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            count_q   <= '0;
            divisor_q <= '0;
        end else begin
            count_q   <= count_d;
            divisor_q <= divisor_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven up/down counter: LOAD/UP/DOWN/STOP over valid/ready, stepping the
// counter N times at a prescaled rate and pulsing done on completion or abort.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int PRESCALE_BITS = DEFAULT_PRESCALE_BITS
) (
    input  logic             clock,
    input  logic             reset_,
    counter_sequencer_if.slave cmd,
    output logic [WIDTH-1:0] counter,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    logic accept;
    logic running;
    logic div_load;
    logic div_enable;
    logic step;

    // STOP is always takeable so an in-flight run can be aborted.
    assign cmd.cmd_ready = (state_q == IDLE) || (cmd.cmd_op == OP_STOP);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign running       = (state_q != IDLE);

    assign div_load   = (state_q == IDLE) && accept
                        && ((cmd.cmd_op == OP_UP) || (cmd.cmd_op == OP_DOWN))
                        && (cmd.cmd_value != '0);
    assign div_enable = running && !accept;

    tick_divider #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_tick_divider (
        .clock   (clock),
        .reset_  (reset_),
        .load    (div_load),
        .enable  (div_enable),
        .divisor (cmd.prescale),
        .strobe  (step)
    );

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        remaining_d = remaining_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_LOAD: begin
                            counter_d = cmd.cmd_value;
                            done_d    = 1'b1;
                        end
                        OP_UP, OP_DOWN: begin
                            if (cmd.cmd_value == '0) begin
                                done_d = 1'b1;
                            end else begin
                                remaining_d = cmd.cmd_value;
                                state_d     = (cmd.cmd_op == OP_UP) ? RUN_UP : RUN_DOWN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN_UP, RUN_DOWN: begin
                // Only STOP can be accepted here, and it pre-empts a coincident step.
                if (accept) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (step) begin
                    tick_d      = 1'b1;
                    counter_d   = (state_q == RUN_UP) ? counter_q + WIDTH'(1)
                                                      : counter_q - WIDTH'(1);
                    remaining_d = remaining_q - WIDTH'(1);
                    if (remaining_q == WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            remaining_q <= '0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            remaining_q <= remaining_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
        end
    end

    assign counter = counter_q;
    assign busy    = running;
    assign tick    = tick_q;
    assign done    = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: a scoreboard of expected tick/done events
// is filled as commands are accepted and drained by a negedge monitor.
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    logic        clock  = 1'b0;
    logic        reset_ = 1'b0;
    logic [15:0] counter;
    logic        busy;
    logic        tick;
    logic        done;

    counter_sequencer_if #(.WIDTH(16), .PRESCALE_BITS(4)) bus ();

    counter_sequencer #(.WIDTH(16), .PRESCALE_BITS(4)) dut (
        .clock   (clock),
        .reset_  (reset_),
        .cmd     (bus),
        .counter (counter),
        .busy    (busy),
        .tick    (tick),
        .done    (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          ev_cyc;
        logic        ev_tick;
        logic        ev_done;
        logic [15:0] ev_cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_cnt = 16'h0;
    logic [15:0] run_base  = 16'h0;
    logic        run_up    = 1'b1;
    int          run_p     = 0;
    int          run_start = 0;
    int          run_end   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pushEv(input int c, input logic t, input logic d, input logic [15:0] v);
        exp_t e;
        e.ev_cyc  = c;
        e.ev_tick = t;
        e.ev_done = d;
        e.ev_cnt  = v;
        exp_q.push_back(e);
    endtask

    // Reference model: what the DUT must emit for a command accepted at cycle acc.
    task automatic pushExpected(input op_t op, input logic [15:0] val, input logic [3:0] p, input int acc);
        int n;
        int steps;
        n = int'(val);
        case (op)
            OP_LOAD: begin
                model_cnt = val;
                pushEv(acc, 1'b0, 1'b1, val);
            end
            OP_UP, OP_DOWN: begin
                if (n == 0) begin
                    pushEv(acc, 1'b0, 1'b1, model_cnt);
                end else begin
                    run_base  = model_cnt;
                    run_up    = (op == OP_UP);
                    run_p     = int'(p);
                    run_start = acc;
                    run_end   = acc + n * (run_p + 1);
                    for (int k = 1; k <= n; k++) begin
                        model_cnt = run_up ? model_cnt + 16'h1 : model_cnt - 16'h1;
                        pushEv(acc + k * (run_p + 1), 1'b1, (k == n), model_cnt);
                    end
                end
            end
            default: begin
                if ((acc - 1 >= run_start) && (acc - 1 < run_end)) begin
                    steps     = (acc - 1 - run_start) / (run_p + 1);
                    model_cnt = run_up ? run_base + 16'(steps) : run_base - 16'(steps);
                    while (exp_q.size() != 0 && exp_q[$].ev_cyc >= acc) void'(exp_q.pop_back());
                    pushEv(acc, 1'b0, 1'b1, model_cnt);
                    run_end = acc;
                end
            end
        endcase
    endtask

    // Called at posedge+1; returns the cycle index right after the accepting edge.
    task automatic applyStimulus(input op_t op, input logic [15:0] val, input logic [3:0] p, output int acc);
        int waited;
        waited        = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_value = val;
        bus.prescale  = p;
        #1;
        while (!bus.cmd_ready && waited < 300) begin
            @(posedge clock);
            #1;
            waited++;
        end
        checkOutput("accept_in_time", 32'(bus.cmd_ready), 32'd1);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clock);
            #1;
            acc           = cyc;
            bus.cmd_valid = 1'b0;
            bus.prescale  = ~p;
            pushExpected(op, val, p, acc);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (reset_) begin
            checkOutput("busy", 32'(busy), 32'((cyc >= run_start) && (cyc < run_end)));
            if (tick || done) begin
                checkOutput("event_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    checkOutput("event_cycle", 32'(cyc), 32'(mon_e.ev_cyc));
                    checkOutput("event_tick", 32'(tick), 32'(mon_e.ev_tick));
                    checkOutput("event_done", 32'(done), 32'(mon_e.ev_done));
                    checkOutput("event_counter", 32'(counter), 32'(mon_e.ev_cnt));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc;
        int a;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_value = 16'h0;
        bus.prescale  = 4'h0;

        repeat (2) @(posedge clock);
        #3;
        checkOutput("reset_counter", 32'(counter), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_tick", 32'(tick), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_ready", 32'(bus.cmd_ready), 32'h1);
        reset_ = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] load 0x1234");
        applyStimulus(OP_LOAD, 16'h1234, 4'h0, acc);
        waitDrain();
        checkOutput("load_value", 32'(counter), 32'h1234);

        $display("[TB] up 3 prescale 0");
        applyStimulus(OP_LOAD, 16'h0010, 4'h0, acc);
        applyStimulus(OP_UP, 16'd3, 4'h0, acc);
        waitDrain();
        checkOutput("up3_final", 32'(counter), 32'h0013);

        $display("[TB] down 3 prescale 3 through zero");
        applyStimulus(OP_LOAD, 16'h0001, 4'h0, acc);
        applyStimulus(OP_DOWN, 16'd3, 4'h3, acc);
        waitDrain();
        checkOutput("down3_final", 32'(counter), 32'hFFFE);

        $display("[TB] up 2 prescale 1 through wrap");
        applyStimulus(OP_LOAD, 16'hFFFF, 4'h0, acc);
        applyStimulus(OP_UP, 16'd2, 4'h1, acc);
        waitDrain();
        checkOutput("wrap_final", 32'(counter), 32'h0001);

        $display("[TB] stop while idle");
        applyStimulus(OP_STOP, 16'h0, 4'h0, acc);
        waitDrain();
        checkOutput("idle_stop_counter", 32'(counter), 32'h0001);

        $display("[TB] stop on sixth step cycle");
        applyStimulus(OP_LOAD, 16'h0100, 4'h0, acc);
        applyStimulus(OP_UP, 16'd100, 4'h2, a);
        n = 0;
        while (cyc != a + 17 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        applyStimulus(OP_STOP, 16'h0, 4'h0, acc);
        checkOutput("stop_accept_cycle", 32'(acc), 32'(a + 18));
        waitDrain();
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        checkOutput("stop_frozen", 32'(counter), 32'h0105);

        $display("[TB] load held off during run");
        applyStimulus(OP_UP, 16'd2, 4'h1, a);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_value = 16'h00AA;
        for (int i = 0; i < 3; i++) begin
            checkOutput("ready_in_run", 32'(bus.cmd_ready), 32'h0);
            @(posedge clock);
            #1;
        end
        applyStimulus(OP_LOAD, 16'h00AA, 4'h0, acc);
        checkOutput("held_load_cycle", 32'(acc), 32'(a + 5));
        waitDrain();
        checkOutput("held_load_value", 32'(counter), 32'h00AA);

        $display("[TB] async reset mid-run");
        applyStimulus(OP_UP, 16'd50, 4'h0, acc);
        repeat (4) @(posedge clock);
        #3;
        reset_ = 1'b0;
        #1;
        checkOutput("midrun_reset_counter", 32'(counter), 32'h0);
        checkOutput("midrun_reset_busy", 32'(busy), 32'h0);
        checkOutput("midrun_reset_tick", 32'(tick), 32'h0);
        checkOutput("midrun_reset_done", 32'(done), 32'h0);
        exp_q.delete();
        model_cnt = 16'h0;
        run_start = 0;
        run_end   = 0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("held_reset_done", 32'(done), 32'h0);
        checkOutput("held_reset_counter", 32'(counter), 32'h0);
        #2;
        reset_ = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(OP_UP, 16'd0, 4'h5, acc);
        waitDrain();
        checkOutput("zero_step_counter", 32'(counter), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
